// File: rtl/mem_read_sequencer_if.sv
// mem_read_sequencer_if: read bus between the sequencer (master) and memory (slave)
interface mem_read_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_data;
  modport master(output mem_address, input mem_ready, mem_data);
  modport slave(input mem_address, output mem_ready, mem_data);
endinterface

// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: walks an address range issuing reads, accumulating checksum and hit/miss statistics
module mem_read_sequencer #(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 32,
  parameter int SUM_W  = 48
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W-1:0]    end_addr,
  mem_read_sequencer_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [SUM_W-1:0]     sum,
  output logic [15:0]          access_count,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
  output logic [31:0]          stall_cycles
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] end_q;
  logic              stalled;
  always_ff @(posedge clk) begin
    if (clear) begin
      state           <= IDLE;
      end_q           <= '0;
      stalled         <= 1'b0;
      mem.mem_address <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      sum             <= '0;
      access_count    <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
      stall_cycles    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sum          <= '0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            stall_cycles <= '0;
            if (end_addr >= start_addr) begin
              end_q           <= end_addr;
              mem.mem_address <= start_addr;
              err             <= 1'b0;
              done            <= 1'b0;
              busy            <= 1'b1;
              state           <= ISSUE;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          stalled <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!mem.mem_ready) begin
            stalled      <= 1'b1;
            stall_cycles <= (stall_cycles == '1) ? stall_cycles : stall_cycles + 32'd1;
          end else begin
            sum          <= sum + SUM_W'(mem.mem_data);
            access_count <= access_count + 16'd1;
            hit_count    <= stalled ? hit_count : hit_count + 16'd1;
            miss_count   <= stalled ? miss_count + 16'd1 : miss_count;
            if (mem.mem_address == end_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem.mem_address <= mem.mem_address + 1'b1;
              state           <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer: directed scoreboard bench for mem_read_sequencer
module tb_mem_read_sequencer;
  typedef struct {
    logic [47:0] sum;
    logic [15:0] acc;
    logic [15:0] hit;
    logic [15:0] miss;
    logic [31:0] stall;
  } exp_t;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [14:0] end_addr = '0;
  logic        busy, done, err;
  logic [47:0] sum;
  logic [15:0] access_count, hit_count, miss_count;
  logic [31:0] stall_cycles;
  int          checks = 0;
  int          errors = 0;
  int          age = 0;
  logic        prev_busy = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [14:0] stall_addr = '0;
  int          stall_k = 0;
  logic        const_mode = 1'b0;
  logic [31:0] const_data = '0;
  exp_t        sb[$];
  mem_read_sequencer_if #(.ADDR_W(15), .WORD_W(32)) bus();
  mem_read_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .mem(bus), .busy(busy), .done(done), .err(err), .sum(sum),
    .access_count(access_count), .hit_count(hit_count), .miss_count(miss_count),
    .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  assign bus.mem_ready = busy === 1'b1 && age > ((bus.mem_address == stall_addr) ? stall_k : 0);
  assign bus.mem_data = const_mode ? const_data : {17'd0, bus.mem_address};
  always @(posedge clk) begin
    #1;
    if (busy === 1'b1 && (!prev_busy || bus.mem_address != prev_addr)) age = 0;
    else age = age + 1;
    prev_busy = (busy === 1'b1);
    prev_addr = bus.mem_address;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 64'(bus.mem_address), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_sum"}, 64'(sum), 0);
    check({tag, "_acc"}, 64'(access_count), 0);
    check({tag, "_hit"}, 64'(hit_count), 0);
    check({tag, "_miss"}, 64'(miss_count), 0);
    check({tag, "_stall"}, 64'(stall_cycles), 0);
  endtask
  task automatic pulse_start(input logic [14:0] sa, input logic [14:0] ea);
    start_addr = sa;
    end_addr = ea;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_result(input string tag, input int budget);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, 64'(done), 1);
    e = sb.pop_front();
    check({tag, "_sum"}, 64'(sum), 64'(e.sum));
    check({tag, "_acc"}, 64'(access_count), 64'(e.acc));
    check({tag, "_hit"}, 64'(hit_count), 64'(e.hit));
    check({tag, "_miss"}, 64'(miss_count), 64'(e.miss));
    check({tag, "_stall"}, 64'(stall_cycles), 64'(e.stall));
  endtask
  initial begin
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    check_zero("reset");
    pulse_start(15'h400, 15'h40F);
    repeat (5) @(negedge clk);
    check("midrun_busy", 64'(busy), 1);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    check_zero("clear_mid");
    @(negedge clk);
    check("clear_idle_busy", 64'(busy), 0);
    const_mode = 1'b1;
    const_data = 32'h0000_00AB;
    sb.push_back('{48'hAB, 16'd1, 16'd1, 16'd0, 32'd0});
    pulse_start(15'h0010, 15'h0010);
    check("single_busy", 64'(busy), 1);
    check("single_addr", 64'(bus.mem_address), 64'h10);
    check("single_done_n0", 64'(done), 0);
    @(negedge clk);
    check("single_done_n1", 64'(done), 0);
    start_addr = 15'h0010;
    end_addr = 15'h0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("single_done_n2", 64'(done), 1);
    check("single_busy_n2", 64'(busy), 0);
    @(negedge clk);
    check("start_at_done_edge_busy", 64'(busy), 0);
    wait_result("single", 20);
    const_mode = 1'b0;
    stall_addr = 15'h400;
    stall_k = 4;
    sb.push_back('{48'h1006, 16'd4, 16'd3, 16'd1, 32'd4});
    pulse_start(15'h400, 15'h403);
    repeat (3) @(negedge clk);
    pulse_start(15'h100, 15'h100);
    wait_result("miss", 100);
    stall_k = 0;
    check("miss_final_addr", 64'(bus.mem_address), 64'h403);
    pulse_start(15'h200, 15'h1FF);
    check("bad_err", 64'(err), 1);
    check("bad_done", 64'(done), 1);
    check("bad_busy", 64'(busy), 0);
    check("bad_acc", 64'(access_count), 0);
    check("bad_sum", 64'(sum), 0);
    repeat (3) @(negedge clk);
    check("bad_addr_held", 64'(bus.mem_address), 64'h403);
    const_mode = 1'b1;
    const_data = 32'hFFFF_FFFF;
    sb.push_back('{48'h1_FFFF_FFFE, 16'd2, 16'd2, 16'd0, 32'd0});
    pulse_start(15'h7FFE, 15'h7FFF);
    check("restart_err", 64'(err), 0);
    check("restart_done", 64'(done), 0);
    check("restart_busy", 64'(busy), 1);
    check("restart_sum", 64'(sum), 0);
    check("restart_acc", 64'(access_count), 0);
    check("restart_addr", 64'(bus.mem_address), 64'h7FFE);
    wait_result("top", 50);
    repeat (2) @(negedge clk);
    check("top_final_addr", 64'(bus.mem_address), 64'h7FFF);
    check("top_still_done", 64'(done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
